// File: rtl/mapper_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mapper_mem_arbiter
// Shares the single 22-bit linear cartridge memory port between the PPU CHR
// fetch path, the CPU PRG fetch path and the ROM loader / save-RAM engine.
// Fixed priority is PPU > CPU > LDR. CPU and LDR each have a starvation guard
// that force-grants them after STARVE_LIMIT lost arbitrations. A stuck memory
// is survived by a timeout that completes the access with 8'hFF read data and
// sets a sticky mem_timeout flag.
//
// Ports
//   clk, reset_n               system clock, asynchronous active-low reset
//   ppu_/cpu_/ldr_ req         level request, held until the matching ack
//   ppu_/cpu_/ldr_ addr/we/din access description, sampled at grant
//   ppu_/cpu_/ldr_ ack         one-cycle completion pulse
//   ppu_/cpu_/ldr_ dout        read data, held until that requester's next completion
//   mem_req                    one-cycle command strobe to the memory controller
//   mem_addr/mem_we/mem_din    latched command of the granted requester
//   mem_ack/mem_dout           memory completion pulse and read data
//   mem_timeout                sticky stuck-memory flag, cleared only by reset
// ---------------------------------------------------------------------------
module mapper_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        ppu_req,
    input  logic [21:0] ppu_addr,
    input  logic        ppu_we,
    input  logic [7:0]  ppu_din,
    output logic        ppu_ack,
    output logic [7:0]  ppu_dout,

    input  logic        cpu_req,
    input  logic [21:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,

    input  logic        ldr_req,
    input  logic [21:0] ldr_addr,
    input  logic        ldr_we,
    input  logic [7:0]  ldr_din,
    output logic        ldr_ack,
    output logic [7:0]  ldr_dout,

    output logic        mem_req,
    output logic [21:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_din,
    input  logic        mem_ack,
    input  logic [7:0]  mem_dout,
    output logic        mem_timeout
);

    localparam int          TW         = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  LIM        = 3'(STARVE_LIMIT);
    // The counter holds the number of WAIT cycles already spent, so the
    // access gives up at the end of the TIMEOUT-th WAIT cycle.
    localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {GNT_PPU, GNT_CPU, GNT_LDR} grant_t;

    state_t        state;
    grant_t        grant;
    grant_t        win;
    logic          any_req;
    logic [21:0]   win_addr;
    logic          win_we;
    logic [7:0]    win_din;
    logic [2:0]    cpu_starve;
    logic [2:0]    ldr_starve;
    logic [TW-1:0] tcnt;
    logic          finish;
    logic [7:0]    rdata;

    // Winner selection: a starved requester overrides the fixed priority,
    // CPU before LDR. A saturated counter only counts while its request is
    // still present, so a requester that went away is never granted.
    always_comb begin
        any_req = ppu_req | cpu_req | ldr_req;
        win     = GNT_LDR;
        if (cpu_req && cpu_starve == LIM)
            win = GNT_CPU;
        else if (ldr_req && ldr_starve == LIM)
            win = GNT_LDR;
        else if (ppu_req)
            win = GNT_PPU;
        else if (cpu_req)
            win = GNT_CPU;

        win_addr = ldr_addr;
        win_we   = ldr_we;
        win_din  = ldr_din;
        case (win)
            GNT_PPU: begin
                win_addr = ppu_addr;
                win_we   = ppu_we;
                win_din  = ppu_din;
            end
            GNT_CPU: begin
                win_addr = cpu_addr;
                win_we   = cpu_we;
                win_din  = cpu_din;
            end
            default: ;
        endcase
    end

    // A WAIT cycle ends the access either on mem_ack or on the last allowed
    // cycle; an ack on that last cycle still counts as a normal completion.
    always_comb begin
        finish = (state == WAIT) && (mem_ack || tcnt == TLAST);
        rdata  = mem_ack ? mem_dout : 8'hFF;
    end

    // Main sequencer: IDLE -> ISSUE -> WAIT -> DONE -> IDLE, all outputs
    // registered. DONE exists so a requester that only drops its request
    // after seeing its ack is not granted a second time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= GNT_PPU;
            cpu_starve  <= '0;
            ldr_starve  <= '0;
            tcnt        <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_din     <= '0;
            mem_timeout <= 1'b0;
            ppu_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            ldr_ack     <= 1'b0;
            ppu_dout    <= '0;
            cpu_dout    <= '0;
            ldr_dout    <= '0;
        end else begin
            mem_req <= 1'b0;
            ppu_ack <= 1'b0;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= win;
                        mem_addr <= win_addr;
                        mem_we   <= win_we;
                        mem_din  <= win_din;
                        mem_req  <= 1'b1;
                        state    <= ISSUE;

                        if (win == GNT_CPU)
                            cpu_starve <= '0;
                        else if (cpu_req && cpu_starve != LIM)
                            cpu_starve <= cpu_starve + 3'd1;

                        if (win == GNT_LDR)
                            ldr_starve <= '0;
                        else if (ldr_req && ldr_starve != LIM)
                            ldr_starve <= ldr_starve + 3'd1;
                    end
                end

                ISSUE: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end

                WAIT: begin
                    if (finish) begin
                        if (!mem_ack)
                            mem_timeout <= 1'b1;
                        case (grant)
                            GNT_PPU: begin
                                ppu_ack <= 1'b1;
                                if (!mem_we)
                                    ppu_dout <= rdata;
                            end
                            GNT_CPU: begin
                                cpu_ack <= 1'b1;
                                if (!mem_we)
                                    cpu_dout <= rdata;
                            end
                            default: begin
                                ldr_ack <= 1'b1;
                                if (!mem_we)
                                    ldr_dout <= rdata;
                            end
                        endcase
                        state <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mapper_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mapper_mem_arbiter
// Scoreboard bench for mapper_mem_arbiter. Directed tests push the expected
// memory commands and requester completions into queues; a monitor on the
// falling clock edge pops and compares whenever the DUT strobes mem_req or
// raises any *_ack. A memory responder answers each mem_req after a chosen
// delay with data = addr[7:0] + 8'h37, so expected read values are constants.
// ---------------------------------------------------------------------------
module tb_mapper_mem_arbiter;

    localparam int PPU = 0;
    localparam int CPU = 1;
    localparam int LDR = 2;

    logic        clk;
    logic        reset_n;
    logic        ppu_req, cpu_req, ldr_req;
    logic [21:0] ppu_addr, cpu_addr, ldr_addr;
    logic        ppu_we, cpu_we, ldr_we;
    logic [7:0]  ppu_din, cpu_din, ldr_din;
    logic        ppu_ack, cpu_ack, ldr_ack;
    logic [7:0]  ppu_dout, cpu_dout, ldr_dout;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic        mem_ack;
    logic [7:0]  mem_dout;
    logic        mem_timeout;

    typedef struct {
        logic [21:0] addr;
        logic        we;
        logic [7:0]  din;
    } cmd_t;

    typedef struct {
        int          who;
        logic [7:0]  dout;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   req_cycles[$];
    int   ack_cycles[$];

    int   checks;
    int   errors;
    int   cyc;
    int   ppu_keep;
    bit   respond_en;
    int   ack_delay;

    mapper_mem_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ppu_req     (ppu_req),
        .ppu_addr    (ppu_addr),
        .ppu_we      (ppu_we),
        .ppu_din     (ppu_din),
        .ppu_ack     (ppu_ack),
        .ppu_dout    (ppu_dout),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_we      (cpu_we),
        .cpu_din     (cpu_din),
        .cpu_ack     (cpu_ack),
        .cpu_dout    (cpu_dout),
        .ldr_req     (ldr_req),
        .ldr_addr    (ldr_addr),
        .ldr_we      (ldr_we),
        .ldr_din     (ldr_din),
        .ldr_ack     (ldr_ack),
        .ldr_dout    (ldr_dout),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_din     (mem_din),
        .mem_ack     (mem_ack),
        .mem_dout    (mem_dout),
        .mem_timeout (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic boundFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout expected=event (cycle %0d)", name, cyc);
    endtask

    task automatic applyStimulus(input int who, input logic [21:0] addr,
                                 input logic we, input logic [7:0] din);
        case (who)
            PPU: begin ppu_addr = addr; ppu_we = we; ppu_din = din; ppu_req = 1'b1; end
            CPU: begin cpu_addr = addr; cpu_we = we; cpu_din = din; cpu_req = 1'b1; end
            default: begin ldr_addr = addr; ldr_we = we; ldr_din = din; ldr_req = 1'b1; end
        endcase
    endtask

    task automatic expectCmd(input logic [21:0] addr, input logic we, input logic [7:0] din);
        cmd_t c;
        c.addr = addr; c.we = we; c.din = din;
        cmd_q.push_back(c);
    endtask

    task automatic expectRsp(input int who, input logic [7:0] dout);
        rsp_t r;
        r.who = who; r.dout = dout;
        rsp_q.push_back(r);
    endtask

    task automatic drain(input int maxc, input string name);
        int n = 0;
        while ((rsp_q.size() != 0 || cmd_q.size() != 0) && n < maxc) begin
            @(posedge clk);
            n++;
        end
        if (rsp_q.size() != 0 || cmd_q.size() != 0) begin
            boundFail(name);
            rsp_q.delete();
            cmd_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic waitMemReq(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mem_req && n < 20);
        if (!mem_req) boundFail(name);
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        ppu_req = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Memory responder: answers each command ack_delay cycles after mem_req.
    initial begin : responder
        bit pending;
        int countdown;
        pending = 0;
        countdown = 0;
        forever begin
            @(posedge clk);
            #1;
            if (respond_en) begin
                mem_ack = 1'b0;
                if (pending && countdown == 0) begin
                    mem_ack  = 1'b1;
                    mem_dout = mem_addr[7:0] + 8'h37;
                    pending  = 0;
                end else if (pending) begin
                    countdown--;
                end
                if (mem_req) begin
                    pending   = 1;
                    countdown = ack_delay - 1;
                end
            end else begin
                pending = 0;
            end
        end
    end

    // Requesters drop their request once they see their ack; the PPU may be
    // told to keep requesting through a number of acks.
    initial begin : droppers
        forever begin
            @(posedge clk);
            #1;
            if (ppu_ack) begin
                if (ppu_keep > 0) ppu_keep--;
                else ppu_req = 1'b0;
            end
            if (cpu_ack) cpu_req = 1'b0;
            if (ldr_ack) ldr_req = 1'b0;
        end
    end

    // Monitor: compares every command strobe and every completion.
    logic [2:0] mon_ackv;
    logic [2:0] mon_exp_oh;
    logic [7:0] mon_dout;
    bit         mon_prev_ack;
    rsp_t       mon_r;
    cmd_t       mon_c;

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_prev_ack = 0;
        end else begin
            mon_ackv = {ldr_ack, cpu_ack, ppu_ack};
            if (mon_ackv != 3'b000) begin
                if (mon_prev_ack) checkOutput("ack_pulse_width", 32'(mon_ackv), 32'd0);
                ack_cycles.push_back(cyc);
                if (rsp_q.size() == 0) begin
                    checkOutput("unexpected_ack", 32'(mon_ackv), 32'd0);
                end else begin
                    mon_r      = rsp_q.pop_front();
                    mon_exp_oh = 3'b001 << mon_r.who;
                    case (mon_r.who)
                        PPU:     mon_dout = ppu_dout;
                        CPU:     mon_dout = cpu_dout;
                        default: mon_dout = ldr_dout;
                    endcase
                    checkOutput("ack_who", 32'(mon_ackv), 32'(mon_exp_oh));
                    checkOutput("ack_dout", 32'(mon_dout), 32'(mon_r.dout));
                end
            end
            mon_prev_ack = (mon_ackv != 3'b000);

            if (mem_req) begin
                req_cycles.push_back(cyc);
                if (cmd_q.size() == 0) begin
                    checkOutput("unexpected_mem_req", 32'(mem_req), 32'd0);
                end else begin
                    mon_c = cmd_q.pop_front();
                    checkOutput("mem_addr", 32'(mem_addr), 32'(mon_c.addr));
                    checkOutput("mem_we", 32'(mem_we), 32'(mon_c.we));
                    checkOutput("mem_din", 32'(mem_din), 32'(mon_c.din));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        checks = 0; errors = 0; cyc = 0; ppu_keep = 0;
        respond_en = 0; ack_delay = 1;
        ppu_req = 0; cpu_req = 0; ldr_req = 0;
        ppu_addr = '0; cpu_addr = '0; ldr_addr = '0;
        ppu_we = 0; cpu_we = 0; ldr_we = 0;
        ppu_din = '0; cpu_din = '0; ldr_din = '0;
        mem_ack = 0; mem_dout = '0;
        reset_n = 0;
        #1;
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_acks", 32'({ppu_ack, cpu_ack, ldr_ack}), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_timeout", 32'(mem_timeout), 32'd0);
        checkOutput("rst_douts", 32'({ppu_dout, cpu_dout, ldr_dout}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        repeat (2) @(posedge clk);
        #1;

        // Test 1: single CPU read, ack 3 cycles after mem_req.
        $display("[TB] test 1 single CPU read");
        req_cycles.delete(); ack_cycles.delete();
        respond_en = 1; ack_delay = 3;
        expectCmd(22'h004123, 1'b0, 8'h00);
        expectRsp(CPU, 8'h5A);
        applyStimulus(CPU, 22'h004123, 1'b0, 8'h00);
        drain(40, "t1_drain");
        if (req_cycles.size() == 1 && ack_cycles.size() == 1)
            checkOutput("t1_latency", 32'(ack_cycles[0] - req_cycles[0]), 32'd4);
        else
            checkOutput("t1_event_count", 32'(req_cycles.size() + ack_cycles.size()), 32'd2);

        // Test 2: all three request together, ack 1 cycle after mem_req.
        $display("[TB] test 2 simultaneous requests");
        req_cycles.delete(); ack_cycles.delete();
        ack_delay = 1;
        expectCmd(22'h000010, 1'b0, 8'h00); expectRsp(PPU, 8'h47);
        expectCmd(22'h008020, 1'b0, 8'h00); expectRsp(CPU, 8'h57);
        expectCmd(22'h100030, 1'b0, 8'h00); expectRsp(LDR, 8'h67);
        applyStimulus(PPU, 22'h000010, 1'b0, 8'h00);
        applyStimulus(CPU, 22'h008020, 1'b0, 8'h00);
        applyStimulus(LDR, 22'h100030, 1'b0, 8'h00);
        drain(60, "t2_drain");
        checkOutput("t2_grant_count", 32'(req_cycles.size()), 32'd3);
        if (req_cycles.size() == 3) begin
            checkOutput("t2_gap_1", 32'(req_cycles[1] - req_cycles[0]), 32'd4);
            checkOutput("t2_gap_2", 32'(req_cycles[2] - req_cycles[1]), 32'd4);
        end

        // Test 3: PPU and LDR held; LDR wins arbitration 5.
        $display("[TB] test 3 starvation guard");
        ppu_keep = 4;
        repeat (4) begin
            expectCmd(22'h001FF0, 1'b0, 8'h00); expectRsp(PPU, 8'h27);
        end
        expectCmd(22'h200001, 1'b0, 8'h00); expectRsp(LDR, 8'h38);
        expectCmd(22'h001FF0, 1'b0, 8'h00); expectRsp(PPU, 8'h27);
        applyStimulus(PPU, 22'h001FF0, 1'b0, 8'h00);
        applyStimulus(LDR, 22'h200001, 1'b0, 8'h00);
        drain(120, "t3_drain");
        checkOutput("t3_ldr_starve", 32'(dut.ldr_starve), 32'd0);

        // Test 4: LDR write, memory never answers.
        $display("[TB] test 4 stuck memory timeout");
        req_cycles.delete(); ack_cycles.delete();
        respond_en = 0; mem_ack = 0;
        expectCmd(22'h3C00A5, 1'b1, 8'h77);
        expectRsp(LDR, 8'h38);
        applyStimulus(LDR, 22'h3C00A5, 1'b1, 8'h77);
        drain(400, "t4_drain");
        if (req_cycles.size() == 1 && ack_cycles.size() == 1)
            checkOutput("t4_latency", 32'(ack_cycles[0] - req_cycles[0]), 32'd256);
        else
            checkOutput("t4_event_count", 32'(req_cycles.size() + ack_cycles.size()), 32'd2);
        checkOutput("t4_timeout_set", 32'(mem_timeout), 32'd1);
        mem_ack = 1; mem_dout = 8'hAB;
        @(posedge clk); #1;
        mem_ack = 0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t4_timeout_sticky", 32'(mem_timeout), 32'd1);
        checkOutput("t4_late_ack_ignored", 32'(ldr_dout), 32'h38);

        // Test 5: reset while waiting on memory.
        $display("[TB] test 5 reset mid-transaction");
        applyReset();
        checkOutput("t5_timeout_cleared", 32'(mem_timeout), 32'd0);
        expectCmd(22'h000777, 1'b0, 8'h00);
        applyStimulus(CPU, 22'h000777, 1'b0, 8'h00);
        waitMemReq("t5_mem_req");
        @(posedge clk); #1;
        reset_n = 0; cpu_req = 0;
        #1;
        checkOutput("t5_mem_req_drop", 32'(mem_req), 32'd0);
        checkOutput("t5_acks_low", 32'({ppu_ack, cpu_ack, ldr_ack}), 32'd0);
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk); #1;
        mem_ack = 1; mem_dout = 8'h99;
        @(posedge clk); #1;
        mem_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_no_stray_dout", 32'(cpu_dout), 32'd0);
        checkOutput("t5_idle_no_req", 32'(mem_req), 32'd0);
        respond_en = 1; ack_delay = 1;
        expectCmd(22'h00ABCD, 1'b0, 8'h00);
        expectRsp(CPU, 8'h04);
        applyStimulus(CPU, 22'h00ABCD, 1'b0, 8'h00);
        drain(40, "t5_drain");

        // Test 6: ack during ISSUE is ignored, later ack completes.
        $display("[TB] test 6 early ack ignored");
        respond_en = 0; mem_ack = 0;
        expectCmd(22'h000042, 1'b0, 8'h00);
        expectRsp(CPU, 8'h11);
        applyStimulus(CPU, 22'h000042, 1'b0, 8'h00);
        waitMemReq("t6_mem_req");
        mem_ack = 1; mem_dout = 8'hEE;
        @(posedge clk); #1;
        mem_ack = 0;
        @(posedge clk); #1;
        mem_ack = 1; mem_dout = 8'h11;
        @(posedge clk); #1;
        mem_ack = 0;
        drain(40, "t6_drain");
        checkOutput("t6_cpu_dout", 32'(cpu_dout), 32'h11);
        checkOutput("t6_no_timeout", 32'(mem_timeout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
